fir_mac_accum: RTL and testbench

//  Downstream MAC stage of the FIR datapath. Consumes coefficient/sample pairs read from
//  the coefficient and sample memories at the addresses the address generator produces.

---
 rtl/fir_mac_accum.sv | 161 ++++++++++++++++
 tb/tb_fir_mac_accum.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_accum.sv
// MAC stage of the FIR datapath: multiplies aligned coefficient/sample pairs, accumulates
// one frame of taps, then rounds, shifts and saturates each finished sum into y_out.
module fir_mac_accum #(
    parameter int H_ADDR_WIDTH  = 4,
    parameter int FILTER_LENGTH = 1 << H_ADDR_WIDTH,
    parameter int COEF_W        = 16,
    parameter int DATA_W        = 16,
    parameter int ACC_W         = COEF_W + DATA_W + H_ADDR_WIDTH,
    parameter int OUT_W         = 16,
    parameter int OUT_SHIFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic signed [COEF_W-1:0] h_in,
    input  logic signed [DATA_W-1:0] x_in,
    output logic signed [OUT_W-1:0]  y_out,
    output logic                     y_valid,
    output logic [31:0]              y_index,
    output logic                     sat_flag,
    output logic                     tap_err
);

    localparam int PROD_W = COEF_W + DATA_W;
    localparam int CNT_W  = H_ADDR_WIDTH + 1;
    localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

    localparam logic [CNT_W-1:0]        LAST_TAP = CNT_W'(FILTER_LENGTH - 1);
    localparam logic signed [ACC_W:0]   ROUND    = (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
    localparam logic signed [ACC_W:0]   SAT_MAX  = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   SAT_MIN  = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          tapCnt_q;
    logic signed [PROD_W-1:0]  pReg_q;
    logic                      pVld_q;
    logic                      pFirst_q;
    logic                      pLast_q;
    logic                      tapErr_q;

    logic signed [ACC_W-1:0]   acc_q;
    logic                      accDone_q;
    logic signed [ACC_W-1:0]   pExt;

    logic signed [OUT_W-1:0]   yOut_q;
    logic                      yValid_q;
    logic [31:0]               yIndex_q;
    logic                      sat_q;

    logic signed [ACC_W:0]     rounded_d;
    logic signed [ACC_W:0]     shifted_d;
    logic signed [OUT_W-1:0]   yOut_d;
    logic                      sat_d;

    // Frame tracking and product register. A beat carrying in_first always opens a new
    // frame; if one was already open it is abandoned, which the accumulator handles by
    // simply restarting from the new first product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tapCnt_q <= '0;
            pReg_q   <= '0;
            pVld_q   <= 1'b0;
            pFirst_q <= 1'b0;
            pLast_q  <= 1'b0;
            tapErr_q <= 1'b0;
        end else begin
            pVld_q   <= 1'b0;
            pFirst_q <= 1'b0;
            pLast_q  <= 1'b0;
            tapErr_q <= 1'b0;
            if (in_valid) begin
                pReg_q <= h_in * x_in;
            end
            if (in_valid && in_first) begin
                tapErr_q <= (state_q == ACC);
                pVld_q   <= 1'b1;
                pFirst_q <= 1'b1;
                if (FILTER_LENGTH == 1) begin
                    pLast_q  <= 1'b1;
                    state_q  <= IDLE;
                    tapCnt_q <= '0;
                end else begin
                    state_q  <= ACC;
                    tapCnt_q <= CNT_W'(1);
                end
            end else if (in_valid && state_q == ACC) begin
                pVld_q <= 1'b1;
                if (tapCnt_q == LAST_TAP) begin
                    pLast_q  <= 1'b1;
                    state_q  <= IDLE;
                    tapCnt_q <= '0;
                end else begin
                    tapCnt_q <= tapCnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign pExt = {{(ACC_W-PROD_W){pReg_q[PROD_W-1]}}, pReg_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q     <= '0;
            accDone_q <= 1'b0;
        end else begin
            accDone_q <= pVld_q & pLast_q;
            if (pVld_q) begin
                acc_q <= pFirst_q ? pExt : acc_q + pExt;
            end
        end
    end

    // One guard bit above the accumulator keeps the rounding add from wrapping.
    always_comb begin
        rounded_d = {acc_q[ACC_W-1], acc_q} + ROUND;
        shifted_d = rounded_d >>> OUT_SHIFT;
        yOut_d    = shifted_d[OUT_W-1:0];
        sat_d     = 1'b0;
        if (shifted_d > SAT_MAX) begin
            yOut_d = OUT_MAX;
            sat_d  = 1'b1;
        end else if (shifted_d < SAT_MIN) begin
            yOut_d = OUT_MIN;
            sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            yOut_q   <= '0;
            yValid_q <= 1'b0;
            yIndex_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            yValid_q <= accDone_q;
            if (accDone_q) begin
                yOut_q   <= yOut_d;
                yIndex_q <= yIndex_q + 32'd1;
                if (sat_d) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

    assign y_out    = yOut_q;
    assign y_valid  = yValid_q;
    assign y_index  = yIndex_q;
    assign sat_flag = sat_q;
    assign tap_err  = tapErr_q;

endmodule

// File: tb/tb_fir_mac_accum.sv
// Bench for fir_mac_accum: directed and random frames compared every cycle against a
// frame-level model that sums h*x per frame and clips the total to 16 bits.
module tb_fir_mac_accum;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_first;
    logic signed [15:0] h_in;
    logic signed [15:0] x_in;
    logic signed [15:0] y_out;
    logic               y_valid;
    logic [31:0]        y_index;
    logic               sat_flag;
    logic               tap_err;

    fir_mac_accum dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_first (in_first),
        .h_in     (h_in),
        .x_in     (x_in),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .y_index  (y_index),
        .sat_flag (sat_flag),
        .tap_err  (tap_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int     cyc;
        longint val;
        bit     sat;
    } exp_t;

    int          compared;
    int          mismatched;
    int          cycle;
    bit          inFrame;
    int          tapCount;
    longint      frameSum;
    exp_t        pendQ[$];
    int          errAt;
    longint      expYout;
    int unsigned expIndex;
    bit          expSat;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Frame-level reference: a finished frame of 16 taps produces its clipped sum two
    // edges after the edge that captured its last beat.
    task automatic modelBeat(input bit first, input logic signed [15:0] h, input logic signed [15:0] x);
        exp_t e;
        if (first) begin
            if (inFrame) errAt = cycle;
            inFrame  = 1'b1;
            tapCount = 1;
            frameSum = longint'(h) * longint'(x);
        end else if (inFrame) begin
            tapCount++;
            frameSum += longint'(h) * longint'(x);
        end
        if (inFrame && tapCount == 16) begin
            inFrame = 1'b0;
            e.cyc   = cycle + 2;
            e.sat   = (frameSum > 32767) || (frameSum < -32768);
            e.val   = (frameSum > 32767) ? 32767 : (frameSum < -32768) ? -32768 : frameSum;
            pendQ.push_back(e);
        end
    endtask

    task automatic checkCycle();
        exp_t e;
        bit   expV;
        expV = (pendQ.size() > 0) && (pendQ[0].cyc == cycle);
        if (expV) begin
            e        = pendQ.pop_front();
            expYout  = e.val;
            expIndex = expIndex + 1;
            expSat   = expSat | e.sat;
        end
        checkOutput("y_valid", longint'(y_valid), longint'(expV));
        checkOutput("y_out", longint'(y_out), expYout);
        checkOutput("y_index", longint'(y_index), longint'(expIndex));
        checkOutput("sat_flag", longint'(sat_flag), longint'(expSat));
        checkOutput("tap_err", longint'(tap_err), longint'(errAt == cycle));
    endtask

    task automatic applyStimulus(input bit rstn, input bit vld, input bit first,
                                 input logic signed [15:0] h, input logic signed [15:0] x);
        rst_n    = rstn;
        in_valid = vld;
        in_first = first;
        h_in     = h;
        x_in     = x;
        @(posedge clk);
        cycle++;
        if (!rstn) begin
            inFrame  = 1'b0;
            tapCount = 0;
            pendQ.delete();
            expYout  = 0;
            expIndex = 0;
            expSat   = 1'b0;
            errAt    = -1;
        end else if (vld) begin
            modelBeat(first, h, x);
        end
        #1;
        checkCycle();
    endtask

    task automatic beat(input bit first, input logic signed [15:0] h, input logic signed [15:0] x);
        applyStimulus(1'b1, 1'b1, first, h, x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    // Counts edges from the one that captured the last beat (that edge is 1) to y_valid.
    task automatic drainAndMeasure(output int edges);
        edges = -1;
        for (int i = 1; i <= 6; i++) begin
            idle(1);
            if (y_valid && edges < 0) edges = i + 1;
        end
    endtask

    int                 lat;
    logic signed [15:0] rh;
    logic signed [15:0] rx;
    int                 abortLen;

    initial begin
        compared   = 0;
        mismatched = 0;
        cycle      = 0;
        inFrame    = 1'b0;
        tapCount   = 0;
        frameSum   = 0;
        errAt      = -1;
        expYout    = 0;
        expIndex   = 0;
        expSat     = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_first   = 1'b0;
        h_in       = '0;
        x_in       = '0;

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
        idle(2);

        $display("[TB] all ones, contiguous");
        for (int k = 0; k < 16; k++) beat(k == 0, 16'sd1, 16'sd1);
        drainAndMeasure(lat);
        checkOutput("ones_latency_edges", lat, 3);
        checkOutput("ones_y_out", longint'(y_out), 16);
        checkOutput("ones_y_index", longint'(y_index), 1);

        $display("[TB] impulse frames");
        for (int k = 0; k < 16; k++) beat(k == 0, 16'(k + 1), (k == 0) ? 16'sd1 : 16'sd0);
        idle(4);
        checkOutput("impulse0_y_out", longint'(y_out), 1);
        for (int k = 0; k < 16; k++) beat(k == 0, 16'(k + 1), (k == 5) ? 16'sd1 : 16'sd0);
        idle(4);
        checkOutput("impulse5_y_out", longint'(y_out), 6);
        checkOutput("impulse5_y_index", longint'(y_index), 3);

        $display("[TB] saturation");
        checkOutput("pre_sat_flag", longint'(sat_flag), 0);
        for (int k = 0; k < 16; k++) beat(k == 0, 16'sd32767, 16'sd32767);
        idle(4);
        checkOutput("satpos_y_out", longint'(y_out), 32767);
        checkOutput("satpos_flag", longint'(sat_flag), 1);
        for (int k = 0; k < 16; k++) beat(k == 0, -16'sd32768, 16'sd32767);
        idle(4);
        checkOutput("satneg_y_out", longint'(y_out), -32768);

        $display("[TB] bubbles every other cycle");
        for (int k = 0; k < 16; k++) begin
            beat(k == 0, 16'sd1, 16'sd1);
            if (k < 15) idle(1);
        end
        drainAndMeasure(lat);
        checkOutput("bubble_latency_edges", lat, 3);
        checkOutput("bubble_y_out", longint'(y_out), 16);

        $display("[TB] early in_first on tap 9");
        for (int k = 0; k < 9; k++) beat(k == 0, 16'sd5, 16'sd7);
        beat(1'b1, 16'sd1, 16'sd1);
        checkOutput("early_tap_err", longint'(tap_err), 1);
        for (int k = 1; k < 16; k++) beat(1'b0, 16'sd1, 16'sd1);
        idle(4);
        checkOutput("early_y_out", longint'(y_out), 16);
        checkOutput("early_y_index", longint'(y_index), 7);

        $display("[TB] reset mid-frame");
        for (int k = 0; k < 7; k++) beat(k == 0, 16'sd9, 16'sd9);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'sd9, 16'sd9);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0);
        for (int k = 0; k < 16; k++) beat(k == 0, 16'sd2, 16'sd3);
        idle(4);
        checkOutput("rst_y_out", longint'(y_out), 96);
        checkOutput("rst_y_index", longint'(y_index), 1);
        checkOutput("rst_sat_flag", longint'(sat_flag), 0);

        $display("[TB] random frames");
        for (int f = 0; f < 16; f++) begin
            if ($urandom_range(0, 3) == 0) beat(1'b0, 16'($urandom), 16'($urandom));
            abortLen = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 15) : 0;
            for (int k = 0; k < abortLen; k++) beat(k == 0, 16'($urandom), 16'($urandom));
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(0, 1) == 0) begin
                    rh = 16'($urandom);
                    rx = 16'($urandom);
                end else begin
                    rh = 16'($signed($urandom_range(0, 511)) - 256);
                    rx = 16'($signed($urandom_range(0, 511)) - 256);
                end
                beat(k == 0, rh, rx);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
